cordic_hyp_engine: RTL and testbench

- Iterative hyperbolic CORDIC engine. Performs one micro-rotation per clock, with the atanh table internal, and supports both rotation and vectoring mode.
- Successor to the single-stage hyperbolic unit. Adds parametrised width and iteration count, automatic repeat iterations (i = 4, 13, 40), a valid/ready handshake and result holding.
- Sits between the fixed-point front end and the exp/ln post-processing, which consumes cosh/sinh or atanh/sqrt results.

---
 rtl/cordic_hyp_engine.sv | 198 +++++++++++++++++++
 tb/tb_cordic_hyp_engine.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_hyp_engine.sv
// Iterative hyperbolic CORDIC engine: one micro-rotation per clock in rotation or
// vectoring mode, with valid/ready handshakes and the result held until consumed.
module cordic_hyp_engine #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 28,
    parameter int ITER  = 16
) (
    input  logic                    CLK,
    input  logic                    RSTN,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    mode,
    input  logic signed [WIDTH-1:0] ix,
    input  logic signed [WIDTH-1:0] iy,
    input  logic signed [WIDTH-1:0] iz,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] ox,
    output logic signed [WIDTH-1:0] oy,
    output logic signed [WIDTH-1:0] oz,
    output logic                    busy
);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

    localparam logic [4:0]  ITER_L = 5'(ITER);
    localparam int          UP     = (FRAC >= 28) ? (FRAC - 28) : 0;
    localparam int          DN     = (FRAC <  28) ? (28 - FRAC) : 0;
    localparam logic [63:0] HALF   = (64'd1 << DN) >> 1;

    // atanh(2^-i) held at Q28 precision and rescaled to FRAC with rounding
    function automatic logic [31:0] atanh_q28(input logic [4:0] idx);
        case (idx)
            5'd1:    atanh_q28 = 32'd147453245;
            5'd2:    atanh_q28 = 32'd68561855;
            5'd3:    atanh_q28 = 32'd33730852;
            5'd4:    atanh_q28 = 32'd16799113;
            5'd5:    atanh_q28 = 32'd8391340;
            5'd6:    atanh_q28 = 32'd4194645;
            5'd7:    atanh_q28 = 32'd2097195;
            5'd8:    atanh_q28 = 32'd1048581;
            5'd9:    atanh_q28 = 32'd524289;
            5'd10:   atanh_q28 = 32'd262144;
            5'd11:   atanh_q28 = 32'd131072;
            5'd12:   atanh_q28 = 32'd65536;
            5'd13:   atanh_q28 = 32'd32768;
            5'd14:   atanh_q28 = 32'd16384;
            5'd15:   atanh_q28 = 32'd8192;
            5'd16:   atanh_q28 = 32'd4096;
            5'd17:   atanh_q28 = 32'd2048;
            5'd18:   atanh_q28 = 32'd1024;
            5'd19:   atanh_q28 = 32'd512;
            5'd20:   atanh_q28 = 32'd256;
            5'd21:   atanh_q28 = 32'd128;
            5'd22:   atanh_q28 = 32'd64;
            5'd23:   atanh_q28 = 32'd32;
            5'd24:   atanh_q28 = 32'd16;
            5'd25:   atanh_q28 = 32'd8;
            5'd26:   atanh_q28 = 32'd4;
            5'd27:   atanh_q28 = 32'd2;
            5'd28:   atanh_q28 = 32'd1;
            5'd29:   atanh_q28 = 32'd1;
            default: atanh_q28 = 32'd0;
        endcase
    endfunction

    state_t                  state_q, state_d;
    logic signed [WIDTH-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
    logic signed [WIDTH-1:0] ox_q, ox_d, oy_q, oy_d, oz_q, oz_d;
    logic [4:0]              i_q, i_d;
    logic                    rep_q, rep_d, mode_q, mode_d;
    logic                    in_ready_q, in_ready_d, out_valid_q, out_valid_d, busy_q, busy_d;

    logic signed [WIDTH-1:0] x_sh_s, y_sh_s, lut_s, x_nx_s, y_nx_s, z_nx_s;
    logic                    dir_pos_s, rep_now_s, last_s;

    assign x_sh_s    = x_q >>> i_q;
    assign y_sh_s    = y_q >>> i_q;
    assign lut_s     = WIDTH'((({32'd0, atanh_q28(i_q)} << UP) + HALF) >> DN);
    assign dir_pos_s = mode_q ? y_q[WIDTH-1] : ~z_q[WIDTH-1];
    // Index 40 of the repeat set can never be reached with ITER <= 30
    assign rep_now_s = ((i_q == 5'd4) || (i_q == 5'd13)) && !rep_q;
    assign last_s    = (i_q == ITER_L) && !rep_now_s;
    assign x_nx_s    = dir_pos_s ? (x_q + y_sh_s) : (x_q - y_sh_s);
    assign y_nx_s    = dir_pos_s ? (y_q + x_sh_s) : (y_q - x_sh_s);
    assign z_nx_s    = dir_pos_s ? (z_q - lut_s)  : (z_q + lut_s);

    // Next-state and datapath update for the IDLE/RUN/DONE sequencer
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        z_d         = z_q;
        ox_d        = ox_q;
        oy_d        = oy_q;
        oz_d        = oz_q;
        i_d         = i_q;
        rep_d       = rep_q;
        mode_d      = mode_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    x_d        = ix;
                    y_d        = iy;
                    z_d        = iz;
                    mode_d     = mode;
                    i_d        = 5'd1;
                    rep_d      = 1'b0;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = S_RUN;
                end else begin
                    in_ready_d = 1'b1;
                end
            end
            S_RUN: begin
                x_d = x_nx_s;
                y_d = y_nx_s;
                z_d = z_nx_s;
                if (rep_now_s) begin
                    rep_d = 1'b1;
                end else begin
                    rep_d = 1'b0;
                    i_d   = i_q + 5'd1;
                end
                if (last_s) begin
                    ox_d        = x_nx_s;
                    oy_d        = y_nx_s;
                    oz_d        = z_nx_s;
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    out_valid_d = 1'b0;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = S_IDLE;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                state_d     = S_IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any operation in flight
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q     <= S_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            ox_q        <= '0;
            oy_q        <= '0;
            oz_q        <= '0;
            i_q         <= 5'd1;
            rep_q       <= 1'b0;
            mode_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            z_q         <= z_d;
            ox_q        <= ox_d;
            oy_q        <= oy_d;
            oz_q        <= oz_d;
            i_q         <= i_d;
            rep_q       <= rep_d;
            mode_q      <= mode_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign ox        = ox_q;
    assign oy        = oy_q;
    assign oz        = oz_q;

endmodule

// File: tb/tb_cordic_hyp_engine.sv
// Directed bench for cordic_hyp_engine: rotation, vectoring, backpressure, reset abort,
// and latency for several ITER values against a real-valued atanh reference.
module tb_cordic_hyp_engine;

    logic clk = 1'b0;
    logic rst_n;
    logic in_valid, aux_valid, mode, out_ready;
    logic signed [31:0] ix, iy, iz;
    logic in_ready, out_valid, busy;
    logic signed [31:0] ox, oy, oz;
    logic rdy4, ov4, bz4, rdy12, ov12, bz12, rdy30, ov30, bz30;
    logic signed [31:0] ox4, oy4, oz4, ox12, oy12, oz12, ox30, oy30, oz30;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    cordic_hyp_engine u_dut (
        .CLK(clk), .RSTN(rst_n), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
        .ix(ix), .iy(iy), .iz(iz), .out_valid(out_valid), .out_ready(out_ready),
        .ox(ox), .oy(oy), .oz(oz), .busy(busy));
    cordic_hyp_engine #(.ITER(4)) u_dut4 (
        .CLK(clk), .RSTN(rst_n), .in_valid(aux_valid), .in_ready(rdy4), .mode(mode),
        .ix(ix), .iy(iy), .iz(iz), .out_valid(ov4), .out_ready(1'b1),
        .ox(ox4), .oy(oy4), .oz(oz4), .busy(bz4));
    cordic_hyp_engine #(.ITER(12)) u_dut12 (
        .CLK(clk), .RSTN(rst_n), .in_valid(aux_valid), .in_ready(rdy12), .mode(mode),
        .ix(ix), .iy(iy), .iz(iz), .out_valid(ov12), .out_ready(1'b1),
        .ox(ox12), .oy(oy12), .oz(oz12), .busy(bz12));
    cordic_hyp_engine #(.ITER(30)) u_dut30 (
        .CLK(clk), .RSTN(rst_n), .in_valid(aux_valid), .in_ready(rdy30), .mode(mode),
        .ix(ix), .iy(iy), .iz(iz), .out_valid(ov30), .out_ready(1'b1),
        .ox(ox30), .oy(oy30), .oz(oz30), .busy(bz30));

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint absl(input longint v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic logic signed [31:0] lut_ref(input int i);
        return int'($atanh(2.0 ** (-i)) * 268435456.0);
    endfunction

    // Bit-exact reference: iterate with repeats at 4 and 13, wrapping 32-bit sums
    function automatic void model(input int iter, input logic m,
                                  input logic signed [31:0] x0, y0, z0,
                                  output logic signed [31:0] xo, yo, zo, output int n);
        logic signed [31:0] x, y, z, xs, ys;
        int  i;
        bit  rep, dpos;
        x = x0; y = y0; z = z0; i = 1; rep = 1'b0; n = 0;
        for (int k = 0; k < 64; k++) begin
            dpos = m ? (y < 0) : (z >= 0);
            xs = x >>> i;
            ys = y >>> i;
            if (dpos) begin x = x + ys; y = y + xs; z = z - lut_ref(i); end
            else      begin x = x - ys; y = y - xs; z = z + lut_ref(i); end
            n++;
            if ((i == 4 || i == 13) && !rep) rep = 1'b1;
            else begin
                if (i == iter) break;
                i++;
                rep = 1'b0;
            end
        end
        xo = x; yo = y; zo = z;
    endfunction

    task automatic start_op(input logic m, input logic signed [31:0] x, y, z);
        @(negedge clk);
        mode = m; ix = x; iy = y; iz = z; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        check_eq("accept_busy", busy, 1);
        check_eq("accept_in_ready", in_ready, 0);
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1 lat++;
        end
    endtask

    task automatic finish_op(input string tag);
        @(negedge clk) out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check_eq({tag, "_release_ov"}, out_valid, 0);
        check_eq({tag, "_release_rdy"}, in_ready, 1);
    endtask

    initial begin
        logic signed [31:0] x1, z1, e1x, e1y, e1z, e2x, e2y, e2z, e3x, e3y, e3z, ex, ey, ez;
        int lat, n, lat4, lat12, lat30;
        logic signed [31:0] r4x, r4y, r4z, r12x, r12y, r12z, r30x, r30y, r30z;

        rst_n = 1'b0; in_valid = 1'b0; aux_valid = 1'b0; out_ready = 1'b0;
        mode = 1'b0; ix = '0; iy = '0; iz = '0;
        x1 = int'(1.20750 * 268435456.0);
        z1 = 32'sd134217728;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_ox", ox, 0);
        @(negedge clk) rst_n = 1'b1;

        // Rotation, nominal angle 0.5
        model(16, 1'b0, x1, 32'sd0, z1, e1x, e1y, e1z, n);
        start_op(1'b0, x1, 32'sd0, z1);
        wait_done(lat);
        check_eq("rot_latency", lat, 18);
        check_eq("rot_ox", ox, e1x);
        check_eq("rot_oy", oy, e1y);
        check_eq("rot_oz", oz, e1z);
        check_eq("rot_ox_tol", absl(ox - longint'(1.127626 * 268435456.0)) <= 8192, 1);
        check_eq("rot_oy_tol", absl(oy - longint'(0.521095 * 268435456.0)) <= 8192, 1);
        check_eq("rot_oz_tol", absl(oz) < 8192, 1);
        finish_op("rot");

        // Vectoring, y/x = 0.5
        model(16, 1'b1, 32'sd536870912, 32'sd268435456, 32'sd0, e2x, e2y, e2z, n);
        start_op(1'b1, 32'sd536870912, 32'sd268435456, 32'sd0);
        wait_done(lat);
        check_eq("vec_latency", lat, 18);
        check_eq("vec_ox", ox, e2x);
        check_eq("vec_oy", oy, e2y);
        check_eq("vec_oz", oz, e2z);
        check_eq("vec_ox_tol", absl(ox - longint'(1.43442 * 268435456.0)) <= 8192, 1);
        check_eq("vec_oy_tol", absl(oy) < 8192, 1);
        check_eq("vec_oz_tol", absl(oz - longint'(0.549306 * 268435456.0)) <= 8192, 1);

        // Backpressure: hold result while a second operand waits at the input
        @(negedge clk);
        mode = 1'b0; ix = x1; iy = '0; iz = -z1; in_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            check_eq("bp_out_valid", out_valid, 1);
            check_eq("bp_in_ready", in_ready, 0);
            check_eq("bp_ox_hold", ox, e2x);
            check_eq("bp_oz_hold", oz, e2z);
        end
        @(negedge clk) out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check_eq("bp_release_ov", out_valid, 0);
        check_eq("bp_release_rdy", in_ready, 1);
        check_eq("bp_release_busy", busy, 0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        check_eq("bp_second_accept", busy, 1);

        // Negative angle: result mirrors the first rotation
        model(16, 1'b0, x1, 32'sd0, -z1, e3x, e3y, e3z, n);
        wait_done(lat);
        check_eq("neg_latency", lat, 18);
        check_eq("neg_ox", ox, e3x);
        check_eq("neg_oy", oy, e3y);
        check_eq("neg_oz", oz, e3z);
        check_eq("sym_ox", absl(ox - e1x) <= 2, 1);
        check_eq("sym_oy", absl(oy + e1y) <= 2, 1);
        finish_op("neg");

        // Reset during RUN discards the operand
        start_op(1'b0, x1, 32'sd0, z1);
        repeat (6) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("abort_in_ready", in_ready, 1);
        check_eq("abort_out_valid", out_valid, 0);
        check_eq("abort_busy", busy, 0);
        check_eq("abort_ox", ox, 0);
        check_eq("abort_oy", oy, 0);
        check_eq("abort_oz", oz, 0);
        @(negedge clk) rst_n = 1'b1;
        start_op(1'b1, 32'sd536870912, 32'sd268435456, 32'sd0);
        wait_done(lat);
        check_eq("post_rst_latency", lat, 18);
        check_eq("post_rst_ox", ox, e2x);
        check_eq("post_rst_oz", oz, e2z);
        finish_op("post_rst");

        // Latency and bit-exact results for ITER = 4, 12, 30
        lat4 = 0; lat12 = 0; lat30 = 0;
        r4x = '0; r4y = '0; r4z = '0; r12x = '0; r12y = '0; r12z = '0;
        r30x = '0; r30y = '0; r30z = '0;
        @(negedge clk);
        mode = 1'b0; ix = x1; iy = '0; iz = z1; aux_valid = 1'b1;
        @(posedge clk);
        #1 aux_valid = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (ov4 && lat4 == 0)   begin lat4 = k;  r4x = ox4;   r4y = oy4;   r4z = oz4;   end
            if (ov12 && lat12 == 0) begin lat12 = k; r12x = ox12; r12y = oy12; r12z = oz12; end
            if (ov30 && lat30 == 0) begin lat30 = k; r30x = ox30; r30y = oy30; r30z = oz30; end
        end
        check_eq("iter4_latency", lat4, 5);
        check_eq("iter12_latency", lat12, 13);
        check_eq("iter30_latency", lat30, 32);
        model(4, 1'b0, x1, 32'sd0, z1, ex, ey, ez, n);
        check_eq("iter4_ox", r4x, ex);
        check_eq("iter4_oy", r4y, ey);
        check_eq("iter4_oz", r4z, ez);
        model(12, 1'b0, x1, 32'sd0, z1, ex, ey, ez, n);
        check_eq("iter12_ox", r12x, ex);
        check_eq("iter12_oy", r12y, ey);
        check_eq("iter12_oz", r12z, ez);
        model(30, 1'b0, x1, 32'sd0, z1, ex, ey, ez, n);
        check_eq("iter30_ox", r30x, ex);
        check_eq("iter30_oy", r30y, ey);
        check_eq("iter30_oz", r30z, ez);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
